// File: rtl/cf_axis_scheduler.sv
// cf_axis_scheduler: time-multiplexes one complementary-filter unit across the X, Y and Z axes
module cf_axis_scheduler #(
    parameter int XY_W        = 16,
    parameter int THETA_W     = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        gyro_x,
    input  logic [15:0]        gyro_y,
    input  logic [15:0]        gyro_z,
    input  logic [XY_W-1:0]    acc_x,
    input  logic [XY_W-1:0]    acc_y,
    input  logic [XY_W-1:0]    acc_z,
    input  logic [THETA_W-1:0] theta_cfg,
    output logic               cf_valid_in,
    output logic [15:0]        cf_gyro,
    output logic [XY_W-1:0]    cf_x_i,
    output logic [XY_W-1:0]    cf_y_i,
    output logic [THETA_W-1:0] cf_theta_i,
    input  logic               cf_valid_out,
    input  logic [15:0]        cf_final,
    input  logic [15:0]        cf_gyro_est,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        x_final,
    output logic [15:0]        y_final,
    output logic [15:0]        z_final,
    output logic [15:0]        x_gyro,
    output logic [15:0]        y_gyro,
    output logic [15:0]        z_gyro,
    output logic               seq_err,
    output logic               busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [1:0]         state, issue_idx, ret_cnt;
    logic [TW-1:0]      tmo;
    logic [15:0]        gx, gy, gz;
    logic [XY_W-1:0]    ax, ay, az;
    logic [THETA_W-1:0] th;
    logic [15:0]        sf [3];
    logic [15:0]        sg [3];
    logic [15:0]        nf [3];
    logic [15:0]        ng [3];
    logic               active, cap, done_now, tmo_hit;
    assign active    = state == ISSUE || state == WAIT;
    assign cap       = active && cf_valid_out && ret_cnt != 2'd3;
    assign done_now  = state == WAIT && (ret_cnt == 2'd3 || (cap && ret_cnt == 2'd2));
    assign tmo_hit   = active && tmo == TW'(TIMEOUT_CYC - 1) && ret_cnt != 2'd3;
    assign in_ready  = rst && state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    // Each axis feeds the CF with the two accel components orthogonal to it
    assign cf_valid_in = state == ISSUE;
    assign cf_gyro     = !cf_valid_in ? '0 : issue_idx == 2'd0 ? gx : issue_idx == 2'd1 ? gy : gz;
    assign cf_x_i      = !cf_valid_in ? '0 : issue_idx == 2'd0 ? ay : ax;
    assign cf_y_i      = !cf_valid_in ? '0 : issue_idx == 2'd2 ? ay : az;
    assign cf_theta_i  = cf_valid_in ? th : '0;
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nf[i] = (cap && ret_cnt == 2'(i)) ? cf_final : sf[i];
            ng[i] = (cap && ret_cnt == 2'(i)) ? cf_gyro_est : sg[i];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            issue_idx <= '0;
            ret_cnt   <= '0;
            tmo       <= '0;
            seq_err   <= 1'b0;
            {gx, gy, gz, ax, ay, az, th} <= '0;
            {x_final, y_final, z_final, x_gyro, y_gyro, z_gyro} <= '0;
            for (int i = 0; i < 3; i++) begin
                sf[i] <= '0;
                sg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                sf[i] <= nf[i];
                sg[i] <= ng[i];
            end
            if (cf_valid_out && !cap) seq_err <= 1'b1;
            if (active) tmo <= tmo + TW'(1);
            if (cap) ret_cnt <= ret_cnt + 2'd1;
            if (in_ready && in_valid) begin
                {gx, gy, gz, ax, ay, az, th} <= {gyro_x, gyro_y, gyro_z, acc_x, acc_y, acc_z, theta_cfg};
                issue_idx <= '0;
                ret_cnt   <= '0;
                tmo       <= '0;
                state     <= ISSUE;
            end else if (done_now) begin
                {x_final, y_final, z_final} <= {nf[0], nf[1], nf[2]};
                {x_gyro, y_gyro, z_gyro}    <= {ng[0], ng[1], ng[2]};
                state <= DONE;
            end else if (tmo_hit) begin
                seq_err <= 1'b1;
                state   <= IDLE;
            end else if (state == ISSUE) begin
                issue_idx <= issue_idx + 2'd1;
                if (issue_idx == 2'd2) state <= WAIT;
            end else if (out_valid && out_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_cf_axis_scheduler.sv
// tb_cf_axis_scheduler: randomized scheduler bench with a latency-configurable CF stand-in
module tb_cf_axis_scheduler;
    localparam int XY_W = 16, THETA_W = 16, TIMEOUT_CYC = 16;
    typedef struct packed {
        logic [2:0][15:0] g;
        logic [2:0][15:0] a;
        logic [15:0]      th;
    } sample_t;
    logic clk = 0, rst = 0;
    logic in_valid = 0, in_ready;
    logic [15:0] gyro_x = 0, gyro_y = 0, gyro_z = 0;
    logic [XY_W-1:0] acc_x = 0, acc_y = 0, acc_z = 0;
    logic [THETA_W-1:0] theta_cfg = 0;
    logic cf_valid_in;
    logic [15:0] cf_gyro;
    logic [XY_W-1:0] cf_x_i, cf_y_i;
    logic [THETA_W-1:0] cf_theta_i;
    logic cf_valid_out = 0;
    logic [15:0] cf_final = 0, cf_gyro_est = 0;
    logic out_valid, out_ready = 0;
    logic [15:0] x_final, y_final, z_final, x_gyro, y_gyro, z_gyro;
    logic seq_err, busy;
    int tests = 0, fails = 0;
    int lat = 4;
    bit idx_mode = 1, drop_z = 0;
    int inj_req = 0, inj_done = 0;

    cf_axis_scheduler #(.XY_W(XY_W), .THETA_W(THETA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z), .theta_cfg(theta_cfg),
        .cf_valid_in(cf_valid_in), .cf_gyro(cf_gyro), .cf_x_i(cf_x_i), .cf_y_i(cf_y_i),
        .cf_theta_i(cf_theta_i), .cf_valid_out(cf_valid_out), .cf_final(cf_final),
        .cf_gyro_est(cf_gyro_est), .out_valid(out_valid), .out_ready(out_ready),
        .x_final(x_final), .y_final(y_final), .z_final(z_final),
        .x_gyro(x_gyro), .y_gyro(y_gyro), .z_gyro(z_gyro), .seq_err(seq_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // CF stand-in: fixed latency, results in issue order, axis index from position in burst
    logic [32:0] pend [16];
    logic iv_s, prev_v = 0;
    logic [15:0] f_s, g_s;
    int k_s, burst = 0;
    initial for (int j = 0; j < 16; j++) pend[j] = '0;
    always @(posedge clk) begin
        iv_s = cf_valid_in;
        k_s  = prev_v ? burst + 1 : 0;
        f_s  = idx_mode ? 16'(k_s + 1) : 16'(cf_gyro + cf_x_i - cf_y_i + cf_theta_i);
        g_s  = idx_mode ? 16'(10 * (k_s + 1)) : 16'(cf_gyro - cf_theta_i);
        if (iv_s) burst = k_s;
        prev_v = iv_s;
        #1;
        for (int j = 0; j < 15; j++) pend[j] = pend[j+1];
        pend[15] = '0;
        if (iv_s && !(drop_z && k_s == 2)) pend[lat-1] = {1'b1, f_s, g_s};
        cf_valid_out = pend[0][32] || inj_req != inj_done;
        cf_final     = pend[0][31:16];
        cf_gyro_est  = pend[0][15:0];
        if (inj_req != inj_done) inj_done = inj_done + 1;
    end

    function automatic void others(input int k, output int p, output int q);
        p = -1;
        q = -1;
        for (int j = 0; j < 3; j++)
            if (j != k) begin
                if (p < 0) p = j;
                else q = j;
            end
    endfunction

    function automatic logic [15:0] exp_f(input sample_t s, input int k);
        int p, q;
        others(k, p, q);
        return idx_mode ? 16'(k + 1) : 16'(s.g[k] + s.a[p] - s.a[q] + s.th);
    endfunction

    function automatic logic [15:0] exp_g(input sample_t s, input int k);
        return idx_mode ? 16'(10 * (k + 1)) : 16'(s.g[k] - s.th);
    endfunction

    function automatic logic [95:0] exp_out(input sample_t s);
        return {exp_f(s, 0), exp_f(s, 1), exp_f(s, 2), exp_g(s, 0), exp_g(s, 1), exp_g(s, 2)};
    endfunction

    function automatic sample_t rand_sample();
        sample_t s;
        s = {$urandom, $urandom, $urandom, $urandom};
        return s;
    endfunction

    task automatic drive(input sample_t s);
        {gyro_z, gyro_y, gyro_x} = s.g;
        {acc_z, acc_y, acc_x}    = s.a;
        theta_cfg                = s.th;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle T+1
    task automatic handshake(input sample_t s);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL handshake_ready: in_ready=%b want 1", in_ready);
        end
        drive(s);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        drive(rand_sample());
    endtask

    task automatic run_txn(input sample_t s, input int l, input int hold, input string name);
        int n, p, q;
        logic [95:0] e;
        lat = l;
        e = exp_out(s);
        handshake(s);
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            tests++;
            if (n <= 3) begin
                others(n - 1, p, q);
                if ({cf_valid_in, cf_gyro, cf_x_i, cf_y_i, cf_theta_i} !== {1'b1, s.g[n-1], s.a[p], s.a[q], s.th}) begin
                    fails++;
                    $display("FAIL %s_issue%0d: got %b/%h/%h/%h/%h want 1/%h/%h/%h/%h", name, n - 1,
                             cf_valid_in, cf_gyro, cf_x_i, cf_y_i, cf_theta_i, s.g[n-1], s.a[p], s.a[q], s.th);
                end
            end else if ({cf_valid_in, cf_gyro, cf_x_i, cf_y_i, cf_theta_i} !== '0) begin
                fails++;
                $display("FAIL %s_idle_operands: cycle %0d got %b/%h/%h/%h/%h want all 0", name, n,
                         cf_valid_in, cf_gyro, cf_x_i, cf_y_i, cf_theta_i);
            end
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL %s_in_ready_busy: cycle %0d got %b want 0", name, n, in_ready);
            end
            @(negedge clk);
            n++;
        end
        tests++;
        if (n != 4 + l) begin
            fails++;
            $display("FAIL %s_latency: out_valid at T+%0d want T+%0d", name, n, 4 + l);
        end
        for (int h = 0; h <= hold; h++) begin
            tests++;
            if ({out_valid, in_ready, x_final, y_final, z_final, x_gyro, y_gyro, z_gyro} !== {2'b10, e}) begin
                fails++;
                $display("FAIL %s_result%0d: got %b%b %h want 10 %h", name, h, out_valid, in_ready,
                         {x_final, y_final, z_final, x_gyro, y_gyro, z_gyro}, e);
            end
            if (h < hold) begin
                in_valid = 1;
                @(negedge clk);
            end
        end
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL %s_accept: out_valid/in_ready/busy=%b%b%b want 010", name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, cf_valid_in, seq_err, busy, cf_gyro, cf_x_i, cf_y_i, cf_theta_i,
             x_final, y_final, z_final, x_gyro, y_gyro, z_gyro} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ctrl=%b%b%b%b%b data nonzero want all 0",
                     in_ready, out_valid, cf_valid_in, seq_err, busy);
        end
        rst = 1;
        @(negedge clk);
        tests++;
        if ({in_ready, busy} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release: in_ready/busy=%b%b want 10", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        sample_t s;
        idx_mode = 1;
        s.g  = {16'sd300, -16'sd200, 16'sd100};
        s.a  = {16'sd30, 16'sd20, 16'sd10};
        s.th = 16'sd5;
        run_txn(s, 4, 0, "basic");
    endtask

    task automatic test_backpressure();
        idx_mode = 0;
        run_txn(rand_sample(), 4, 5, "backpressure");
    endtask

    task automatic test_latency1();
        idx_mode = 0;
        run_txn(rand_sample(), 1, 0, "lat1");
    endtask

    task automatic test_back_to_back();
        idx_mode = 0;
        for (int i = 0; i < 8; i++) run_txn(rand_sample(), $urandom_range(1, 6), $urandom_range(0, 3), "b2b");
    endtask

    task automatic test_timeout();
        logic [95:0] prev;
        idx_mode = 0;
        drop_z   = 1;
        lat      = 4;
        prev = {x_final, y_final, z_final, x_gyro, y_gyro, z_gyro};
        handshake(rand_sample());
        for (int n = 1; n <= 17; n++) begin
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL timeout_no_valid: cycle %0d out_valid=%b want 0", n, out_valid);
            end
            if (n == 16) begin
                tests++;
                if ({busy, seq_err} !== 2'b10) begin
                    fails++;
                    $display("FAIL timeout_early: busy/seq_err=%b%b want 10 at T+16", busy, seq_err);
                end
            end
            if (n < 17) @(negedge clk);
        end
        tests++;
        if ({busy, seq_err, x_final, y_final, z_final, x_gyro, y_gyro, z_gyro} !== {2'b01, prev}) begin
            fails++;
            $display("FAIL timeout_abort: busy/seq_err=%b%b outputs %h want 01 %h", busy, seq_err,
                     {x_final, y_final, z_final, x_gyro, y_gyro, z_gyro}, prev);
        end
        drop_z = 0;
        run_txn(rand_sample(), 3, 0, "post_timeout");
        tests++;
        if (seq_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: seq_err=%b want 1", seq_err);
        end
    endtask

    task automatic test_reset_mid();
        idx_mode = 0;
        lat      = 4;
        handshake(rand_sample());
        repeat (2) @(negedge clk);
        rst = 0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rmid_in_ready: in_ready=%b want 0 during reset", in_ready);
        end
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid, cf_valid_in, seq_err, busy, cf_gyro, cf_x_i, cf_y_i, cf_theta_i,
             x_final, y_final, z_final, x_gyro, y_gyro, z_gyro} !== '0) begin
            fails++;
            $display("FAIL rmid_outputs: ctrl=%b%b%b%b%b want all 0", in_ready, out_valid, cf_valid_in, seq_err, busy);
        end
        rst = 1;
        @(negedge clk);
        tests++;
        if ({in_ready, seq_err} !== 2'b10) begin
            fails++;
            $display("FAIL rmid_release: in_ready/seq_err=%b%b want 10", in_ready, seq_err);
        end
        @(negedge clk);
        tests++;
        if (seq_err !== 1'b1) begin
            fails++;
            $display("FAIL rmid_late_result: seq_err=%b want 1", seq_err);
        end
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, out_valid, in_ready} !== 3'b001) begin
            fails++;
            $display("FAIL rmid_idle: busy/out_valid/in_ready=%b%b%b want 001", busy, out_valid, in_ready);
        end
    endtask

    task automatic test_spurious();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        tests++;
        if (seq_err !== 1'b0) begin
            fails++;
            $display("FAIL spur_clear: seq_err=%b want 0", seq_err);
        end
        inj_req++;
        repeat (2) @(negedge clk);
        tests++;
        if ({seq_err, busy, out_valid, in_ready, x_final} !== {4'b1001, 16'h0}) begin
            fails++;
            $display("FAIL spur_idle: seq_err/busy/out_valid/in_ready=%b%b%b%b x_final=%h want 1001 0000",
                     seq_err, busy, out_valid, in_ready, x_final);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_latency1();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
